// File: rtl/mem_latency_unit.sv
// rtl/mem_latency_unit.sv - fixed-latency line-wide backing store with request/abort handshake
module mem_latency_unit #(
  parameter int cache_line_width = 256,
  parameter int addr_width       = 16,
  parameter int num_lines        = 64,
  parameter int latency          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        petition,
  input  logic [addr_width-1:0]       address,
  input  logic                        we,
  input  logic [cache_line_width-1:0] data_write,
  output logic                        serviceReady,
  output logic [cache_line_width-1:0] data_read,
  output logic                        busy
);

  localparam int idx_w = $clog2(num_lines);
  localparam int cnt_w = $clog2(latency) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [cnt_w-1:0]            cnt_q, cnt_d;
  logic [idx_w-1:0]            idx_q;
  logic                        we_q;
  logic [cache_line_width-1:0] wdata_q;
  logic [cache_line_width-1:0] rdata_q, rdata_d;
  logic                        accept;

  // Backing store: starts at zero and is deliberately left out of reset.
  logic [cache_line_width-1:0] mem_q [num_lines] = '{default: '0};

  // Low offset bits and bits above the index are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address;

  assign accept = (state_q == IDLE) && petition;

  // Next state, wait counter and the line to present during DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (petition) begin
          state_d = BUSY;
          cnt_d   = cnt_w'(latency - 2);
        end
      end
      BUSY: begin
        if (!petition) begin
          // Requester gave up: drop the request without touching memory.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_w'(1);
        end else begin
          state_d = DONE;
          // A write echoes its own data so the requester sees the new line.
          rdata_d = we_q ? wdata_q : mem_q[idx_q];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and read-data registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture at the accepting edge; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= address[idx_w+4:5];
      we_q    <= we;
      wdata_q <= data_write;
    end
  end

  // Commit writes on the edge leaving DONE; reset forces IDLE so it blocks this.
  always_ff @(posedge clk) begin
    if (state_q == DONE && we_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign serviceReady = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign data_read    = rdata_q;

endmodule

// File: doc/mem_latency_unit.md
MEM_LATENCY_UNIT -- requirements
Module: mem_latency_unit

Interface
REQ-001 Parameters SHALL be:
- cache_line_width, default 256, line width in bits.
- addr_width, default 16, byte address width.
- num_lines, default 64, power of 2, backing store depth in lines.
- latency, default 4, minimum 2, request-to-response cycles.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- petition  in  1  request, held by the requester until serviceReady.
- address  in  addr_width  byte address of the line.
- we  in  1  1 = line write, 0 = line read.
- data_write  in  cache_line_width  write line.
- serviceReady  out  1  one-cycle completion pulse.
- data_read  out  cache_line_width  read line, valid while serviceReady=1.
- busy  out  1  a request is in flight.

Function
REQ-004 Line index SHALL be address[log2(num_lines)+4 : 5].
- address[4:0] is ignored.
- Upper bits are ignored, so the index wraps modulo num_lines.
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE, one-hot or binary.
REQ-006 In IDLE with petition=1 at a rising edge (the accepting edge A), the block SHALL capture index, we and data_write, load the counter with latency-2, and move to BUSY.
REQ-007 In BUSY with petition=1:
- counter>0: decrement the counter each edge.
- counter=0: move to DONE at the next edge.
REQ-008 In DONE, serviceReady SHALL be 1 for exactly one cycle, which is the cycle after edge A+latency-1.
REQ-009 DONE SHALL always return to IDLE at the next edge.
REQ-010 A read SHALL drive data_read with mem[captured index] throughout DONE; data_read SHALL hold its last value outside DONE.
REQ-011 A write SHALL update mem[captured index] with the captured data_write at the edge leaving DONE.
- data_read SHALL show the new line during DONE (write-through echo).
REQ-012 Inputs SHALL be ignored after the accepting edge; changes to address, we or data_write during BUSY have no effect.
REQ-013 If petition falls during BUSY, the block SHALL abort at the next edge:
- return to IDLE.
- no write, no serviceReady.
REQ-014 Petition still high in the cycle after DONE SHALL be accepted as a new request at that edge. Requesters drop petition upon serviceReady.
REQ-015 busy SHALL be 1 in BUSY and DONE, and 0 in IDLE.
REQ-016 Back-to-back throughput SHALL be one request per latency+1 cycles.
REQ-017 The memory array SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-018 While reset=0, the block SHALL be forced asynchronously to:
- state IDLE, counter 0.
- serviceReady 0, busy 0.
- data_read all zeros.
REQ-019 Reset asserted mid-request SHALL discard the request with no write to memory.
REQ-020 After reset deasserts, the first edge with petition=1 SHALL be the accepting edge.

Verification
REQ-021 Read after power-up: petition=1, we=0, address=16'h0040 at edge A -> serviceReady=1 only in the cycle after edge A+3; data_read=0; busy=1 for 4 cycles.
REQ-022 Write then read: write line 256'h...DEADBEEF to address 16'h0020, then read 16'h003F -> read returns ...DEADBEEF (same line; low bits ignored).
REQ-023 Wrap: write 256'h1 to address 16'h0800 (index 64 mod 64 = 0), then read 16'h0000 -> data_read=256'h1.
REQ-024 Abort: petition drops one cycle after acceptance of a write to 16'h0060 -> no serviceReady; IDLE next edge; a subsequent read of 16'h0060 returns the old value.
REQ-025 Reset mid-request: reset=0 two cycles into a write -> serviceReady=0, busy=0, data_read=0 immediately; memory line unchanged.
REQ-026 Back-to-back: petition held high across two reads -> second serviceReady exactly 5 cycles after the first (latency=4).
